bcd_digit_source: RTL and testbench

Producer side of the 4-digit display path. Converts an unsigned binary value to four BCD digits using a sequential double-dabble engine with a start/busy/done handshake. Also generates the free-running 2-bit refreshcounter that the digit multiplexer uses to select digits. Digit outputs feed the multiplexer's digit1..digit4 inputs directly and stay stable between conversions.

---
 rtl/bcd_digit_source.sv | 183 ++++++++++++++++++
 tb/tb_bcd_digit_source.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_source.sv
// ---------------------------------------------------------------------------
// bcd_digit_source
// Producer side of the 4-digit display path.
//  - A sequential double-dabble engine converts bin_in (capped at 9999) into
//    four BCD digits. Handshake: start / busy / done.
//  - A free-running prescaler drives a 2-bit digit-slot select
//    (refreshcounter) for the digit multiplexer.
//
// Optional feature macro: BCD_BLANK_EN
//   When defined, leading zeros are replaced by the blank code 4'b1111.
//   digit1 is never blanked.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   conversion request, sampled only when idle
//   bin_in         in   unsigned value to convert [BIN_WIDTH]
//   busy           out  conversion in progress
//   done           out  one-cycle pulse when new digits become visible
//   overflow       out  last accepted bin_in exceeded 9999
//   digit1..digit4 out  ones..thousands digit (BCD or blank code)
//   refreshcounter out  digit-slot select, 0,1,2,3,0...
// ---------------------------------------------------------------------------
module bcd_digit_source #(
    parameter int unsigned BIN_WIDTH   = 14,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_WIDTH   = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [3:0]           digit1,
    output logic [3:0]           digit2,
    output logic [3:0]           digit3,
    output logic [3:0]           digit4,
    output logic [1:0]           refreshcounter
);

    localparam int unsigned CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned MAX_DEC = 9999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [BIN_WIDTH-1:0] operand_q, operand_d;
    logic [CNT_W-1:0]     iter_q, iter_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [BCD_W-1:0]     digits_q, digits_d;
    logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [1:0]           refresh_q, refresh_d;

    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W-1:0]     fin_digits_c;
    logic                 over_c;

    assign over_c = (32'(bin_in) > 32'(MAX_DEC));

    // Add-3 correction for every nibble >= 5 (no carry between nibbles)
    always_comb begin
        adj_c = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final digit image, optionally with leading-zero blanking
    always_comb begin
        fin_digits_c = scratch_q;
`ifdef BCD_BLANK_EN
        begin
            logic blank4, blank3, blank2;
            blank4 = (scratch_q[15:12] == 4'd0);
            blank3 = blank4 && (scratch_q[11:8] == 4'd0);
            blank2 = blank3 && (scratch_q[7:4] == 4'd0);
            if (blank4) fin_digits_c[15:12] = 4'hF;
            if (blank3) fin_digits_c[11:8]  = 4'hF;
            if (blank2) fin_digits_c[7:4]   = 4'hF;
        end
`endif
    end

    // Conversion FSM: next state and datapath
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        operand_d = operand_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        digits_d  = digits_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    operand_d = over_c ? BIN_WIDTH'(MAX_DEC) : bin_in;
                    ovf_d     = over_c;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, operand_d} = {adj_c[BCD_W-2:0], operand_q, 1'b0};
                iter_d = iter_q + CNT_W'(1);
                if (iter_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                digits_d = fin_digits_c;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Free-running digit-slot prescaler
    always_comb begin
        prescaler_d = prescaler_q + DIV_WIDTH'(1);
        refresh_d   = refresh_q;
        if (prescaler_q == DIV_WIDTH'(REFRESH_DIV - 1)) begin
            prescaler_d = '0;
            refresh_d   = refresh_q + 2'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scratch_q   <= '0;
            operand_q   <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            digits_q    <= '0;
            prescaler_q <= '0;
            refresh_q   <= '0;
        end else begin
            state_q     <= state_d;
            scratch_q   <= scratch_d;
            operand_q   <= operand_d;
            iter_q      <= iter_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            digits_q    <= digits_d;
            prescaler_q <= prescaler_d;
            refresh_q   <= refresh_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign digit1         = digits_q[3:0];
    assign digit2         = digits_q[7:4];
    assign digit3         = digits_q[11:8];
    assign digit4         = digits_q[15:12];
    assign refreshcounter = refresh_q;

endmodule

// File: tb/tb_bcd_digit_source.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_source
// Directed plus randomized bench for bcd_digit_source. Expected digits come
// from decimal arithmetic on the capped input; expected refreshcounter comes
// from the number of clock edges since reset.
// ---------------------------------------------------------------------------
module tb_bcd_digit_source;

    localparam int unsigned BW  = 14;
    localparam int unsigned DIV = 4;
    localparam int unsigned LAT = BW + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [BW-1:0] bin_in;
    logic          busy, done, overflow;
    logic [3:0]    digit1, digit2, digit3, digit4;
    logic [1:0]    refreshcounter;

    int checks = 0;
    int errors = 0;
    int cyc;

    bcd_digit_source #(
        .BIN_WIDTH  (BW),
        .REFRESH_DIV(DIV),
        .DIV_WIDTH  (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bin_in        (bin_in),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .digit1        (digit1),
        .digit2        (digit2),
        .digit3        (digit3),
        .digit4        (digit4),
        .refreshcounter(refreshcounter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges elapsed since reset was last released
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of min(v,9999), with optional blanking
    function automatic logic [15:0] exp_digits(input int v);
        int c;
        logic [3:0] d [4];
        c = (v > 9999) ? 9999 : v;
        d[0] = 4'(c % 10);
        d[1] = 4'((c / 10) % 10);
        d[2] = 4'((c / 100) % 10);
        d[3] = 4'(c / 1000);
`ifdef BCD_BLANK_EN
        if (c < 1000) d[3] = 4'hF;
        if (c < 100)  d[2] = 4'hF;
        if (c < 10)   d[1] = 4'hF;
`endif
        return {d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [15:0] shown();
        return {digit4, digit3, digit2, digit1};
    endfunction

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        check("refresh", 32'(refreshcounter), 32'((cyc / DIV) % 4));
    endtask

    // Wait for done after an accepted start; optional mid-flight start pulse
    task automatic wait_result(input int v, input int glitch_at, input int glitch_v);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (glitch_at >= 0 && n == glitch_at) begin
                start  = 1'b1;
                bin_in = BW'(glitch_v);
            end else if (glitch_at >= 0 && n == glitch_at + 1) begin
                start = 1'b0;
            end
            tick();
            n++;
            if (done) seen = 1'b1;
            else      check("busy_during", 32'(busy), 32'd1);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(LAT));
        check("digits", 32'(shown()), 32'(exp_digits(v)));
        check("overflow", 32'(overflow), 32'(v > 9999));
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic convert(input int v);
        start  = 1'b1;
        bin_in = BW'(v);
        tick();
        start = 1'b0;
        check("busy_accept", 32'(busy), 32'd1);
        wait_result(v, -1, 0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int v, v2;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digits", 32'(shown()), 32'd0);

        // Free run, then reset mid-run
        repeat (11) tick();
        reset = 1'b1;
        #1;
        check("rst2_rc", 32'(refreshcounter), 32'd0);
        check("rst2_done", 32'(done), 32'd0);
        check("rst2_ovf", 32'(overflow), 32'd0);
        check("rst2_digits", 32'(shown()), 32'd0);
        tick();
        reset = 1'b0;
        repeat (17) tick();

        // Directed conversions
        convert(1234);
        convert(12000);
        convert(42);

        // Start pulse while busy is ignored and not queued
        start  = 1'b1;
        bin_in = BW'(1234);
        tick();
        start = 1'b0;
        wait_result(1234, 5, 5678);
        repeat (20) begin
            tick();
            check("no_second_done", 32'(done), 32'd0);
        end
        check("glitch_digits", 32'(shown()), 32'(exp_digits(1234)));

        // Start held high: back-to-back, bin_in re-sampled on each accept
        start  = 1'b1;
        bin_in = BW'(8765);
        tick();
        bin_in = BW'(16383);
        wait_result(8765, -1, 0);
        tick();
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        check("b2b_accept_done", 32'(done), 32'd0);
        wait_result(16383, -1, 0);
        tick();

        // Values of interest for blanking and boundaries
        convert(7);
        convert(1005);
        convert(0);
        convert(9999);
        convert(10000);
        convert(10);

        // Randomized conversions
        for (int k = 0; k < 10; k++) begin
            v = (k % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
            convert(v);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        // Reset in the middle of a conversion aborts it
        v2 = 4321;
        convert(v2);
        start  = 1'b1;
        bin_in = BW'(5555);
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_digits", 32'(shown()), 32'd0);
        check("abort_rc", 32'(refreshcounter), 32'd0);
        tick();
        reset = 1'b0;
        repeat (20) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_digits_after", 32'(shown()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
